// File: rtl/matrix_op_dispatcher.sv
// ============================================================================
// matrix_op_dispatcher : launches one matrix op unit per command, lends it the
// shared BRAM read port and writer port, and returns its final status.
// Revision: 1.0
// ============================================================================
`default_nettype none

package matrix_op_pkg;
   localparam int MATRIX_ADDR_WIDTH = 12;
   localparam int MATRIX_DATA_WIDTH = 16;

   typedef enum logic [2:0] {
      MATRIX_OP_STATUS_IDLE         = 3'd0,
      MATRIX_OP_STATUS_BUSY         = 3'd1,
      MATRIX_OP_STATUS_SUCCESS      = 3'd2,
      MATRIX_OP_STATUS_ERR_ID       = 3'd3,
      MATRIX_OP_STATUS_ERR_INTERNAL = 3'd4,
      MATRIX_OP_STATUS_ERR_DIM      = 3'd5
   } matrix_op_status_e;
endpackage

module matrix_op_dispatcher
   import matrix_op_pkg::*;
#(
   parameter int NUM_UNITS      = 4,
   parameter int ADDR_WIDTH     = MATRIX_ADDR_WIDTH,
   parameter int DATA_WIDTH     = MATRIX_DATA_WIDTH,
   parameter int LAUNCH_TIMEOUT = 16
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  cmd_start,
   input  logic [2:0]                            cmd_op,
   input  logic [2:0]                            cmd_a_id,
   input  logic [2:0]                            cmd_b_id,
   output logic                                  busy,
   output logic                                  done,
   output matrix_op_status_e                     status,
   output logic [NUM_UNITS-1:0]                  unit_start,
   output logic [2:0]                            unit_a_id,
   output logic [2:0]                            unit_b_id,
   input  logic [NUM_UNITS-1:0]                  unit_busy,
   input  matrix_op_status_e [NUM_UNITS-1:0]     unit_status,
   input  logic [NUM_UNITS-1:0][ADDR_WIDTH-1:0]  unit_read_addr,
   output logic [ADDR_WIDTH-1:0]                 read_addr,
   input  logic [NUM_UNITS-1:0]                  unit_write_request,
   input  logic [NUM_UNITS-1:0]                  unit_data_valid,
   input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  unit_data_in,
   input  logic [NUM_UNITS-1:0][2:0]             unit_matrix_id,
   input  logic [NUM_UNITS-1:0][7:0]             unit_actual_rows,
   input  logic [NUM_UNITS-1:0][7:0]             unit_actual_cols,
   output logic                                  write_request,
   output logic                                  data_valid,
   output logic [DATA_WIDTH-1:0]                 data_in,
   output logic [2:0]                            matrix_id,
   output logic [7:0]                            actual_rows,
   output logic [7:0]                            actual_cols,
   input  logic                                  write_ready,
   input  logic                                  writer_ready,
   input  logic                                  write_done,
   output logic [NUM_UNITS-1:0]                  unit_write_ready,
   output logic [NUM_UNITS-1:0]                  unit_writer_ready,
   output logic [NUM_UNITS-1:0]                  unit_write_done
);

   localparam int C_SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam int C_CNT_W = $clog2(LAUNCH_TIMEOUT + 1);
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(LAUNCH_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CHECK     = 3'd1,
      S_LAUNCH    = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_RUN       = 3'd4,
      S_CAPTURE   = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   state_t               r_state;
   logic [2:0]           r_sel;
   logic [C_CNT_W-1:0]   r_cnt;
   logic [C_SEL_W-1:0]   w_idx;
   logic                 w_sel_bad;
   logic                 w_active;

   assign w_idx     = r_sel[C_SEL_W-1:0];
   assign w_sel_bad = (32'(r_sel) >= NUM_UNITS);
   assign w_active  = (r_state == S_LAUNCH) || (r_state == S_WAIT_BUSY) ||
                      (r_state == S_RUN)    || (r_state == S_CAPTURE);
   assign busy      = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_sel      <= '0;
         r_cnt      <= '0;
         unit_a_id  <= '0;
         unit_b_id  <= '0;
         unit_start <= '0;
         done       <= 1'b0;
         status     <= MATRIX_OP_STATUS_IDLE;
      end else begin
         unit_start <= '0;
         done       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_start) begin
                  r_sel     <= cmd_op;
                  unit_a_id <= cmd_a_id;
                  unit_b_id <= cmd_b_id;
                  r_state   <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (w_sel_bad) begin
                  status  <= MATRIX_OP_STATUS_ERR_ID;
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  status            <= MATRIX_OP_STATUS_BUSY;
                  unit_start[w_idx] <= 1'b1;
                  r_state           <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_cnt   <= '0;
               r_state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (unit_busy[w_idx]) begin
                  r_state <= S_RUN;
               end else if (r_cnt == C_CNT_LAST) begin
                  status  <= MATRIX_OP_STATUS_ERR_INTERNAL;
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + C_CNT_W'(1);
               end
            end
            S_RUN: begin
               if (!unit_busy[w_idx]) begin
                  r_state <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               // Sampled a cycle after busy falls so the unit's last status write lands.
               status  <= unit_status[w_idx];
               done    <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Only the selected unit sees the shared ports; the rest get zeros.
   always_comb begin
      read_addr         = '0;
      write_request     = 1'b0;
      data_valid        = 1'b0;
      data_in           = '0;
      matrix_id         = '0;
      actual_rows       = '0;
      actual_cols       = '0;
      unit_write_ready  = '0;
      unit_writer_ready = '0;
      unit_write_done   = '0;
      if (w_active) begin
         read_addr                = unit_read_addr[w_idx];
         write_request            = unit_write_request[w_idx];
         data_valid               = unit_data_valid[w_idx];
         data_in                  = unit_data_in[w_idx];
         matrix_id                = unit_matrix_id[w_idx];
         actual_rows              = unit_actual_rows[w_idx];
         actual_cols              = unit_actual_cols[w_idx];
         unit_write_ready[w_idx]  = write_ready;
         unit_writer_ready[w_idx] = writer_ready;
         unit_write_done[w_idx]   = write_done;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_matrix_op_dispatcher.sv
// ============================================================================
// tb_matrix_op_dispatcher : directed self-checking bench for the dispatcher.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_matrix_op_dispatcher;
   import matrix_op_pkg::*;

   localparam int NU = 4;
   localparam int AW = MATRIX_ADDR_WIDTH;
   localparam int DW = MATRIX_DATA_WIDTH;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   cmd_start;
   logic [2:0]             cmd_op, cmd_a_id, cmd_b_id;
   logic                   busy, done;
   matrix_op_status_e      status;
   logic [NU-1:0]          unit_start;
   logic [2:0]             unit_a_id, unit_b_id;
   logic [NU-1:0]          unit_busy;
   matrix_op_status_e [NU-1:0] unit_status;
   logic [NU-1:0][AW-1:0]  unit_read_addr;
   logic [AW-1:0]          read_addr;
   logic [NU-1:0]          unit_write_request, unit_data_valid;
   logic [NU-1:0][DW-1:0]  unit_data_in;
   logic [NU-1:0][2:0]     unit_matrix_id;
   logic [NU-1:0][7:0]     unit_actual_rows, unit_actual_cols;
   logic                   write_request, data_valid;
   logic [DW-1:0]          data_in;
   logic [2:0]             matrix_id;
   logic [7:0]             actual_rows, actual_cols;
   logic                   write_ready, writer_ready, write_done;
   logic [NU-1:0]          unit_write_ready, unit_writer_ready, unit_write_done;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int start_cnt = 0;
   int n, s0, d0;

   always #5 clk = ~clk;

   matrix_op_dispatcher #(.NUM_UNITS(NU), .LAUNCH_TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_op(cmd_op),
      .cmd_a_id(cmd_a_id), .cmd_b_id(cmd_b_id), .busy(busy), .done(done),
      .status(status), .unit_start(unit_start), .unit_a_id(unit_a_id),
      .unit_b_id(unit_b_id), .unit_busy(unit_busy), .unit_status(unit_status),
      .unit_read_addr(unit_read_addr), .read_addr(read_addr),
      .unit_write_request(unit_write_request), .unit_data_valid(unit_data_valid),
      .unit_data_in(unit_data_in), .unit_matrix_id(unit_matrix_id),
      .unit_actual_rows(unit_actual_rows), .unit_actual_cols(unit_actual_cols),
      .write_request(write_request), .data_valid(data_valid), .data_in(data_in),
      .matrix_id(matrix_id), .actual_rows(actual_rows), .actual_cols(actual_cols),
      .write_ready(write_ready), .writer_ready(writer_ready), .write_done(write_done),
      .unit_write_ready(unit_write_ready), .unit_writer_ready(unit_writer_ready),
      .unit_write_done(unit_write_done)
   );

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (|unit_start) start_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int bound, output int cycles);
      cycles = 0;
      while (cycles < bound) begin
         @(negedge clk);
         cycles++;
         if (done) break;
      end
      check("done_seen", 32'(done), 32'd1);
   endtask

   task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
      cmd_start = 1'b1; cmd_op = op; cmd_a_id = a; cmd_b_id = b;
      @(negedge clk);
      cmd_start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; cmd_start = 1'b0; cmd_op = '0; cmd_a_id = '0; cmd_b_id = '0;
      unit_busy = '0; unit_status = {NU{MATRIX_OP_STATUS_IDLE}};
      unit_read_addr = '0; unit_write_request = '0; unit_data_valid = '0;
      unit_data_in = '0; unit_matrix_id = '0; unit_actual_rows = '0; unit_actual_cols = '0;
      write_ready = 1'b0; writer_ready = 1'b0; write_done = 1'b0;
      unit_read_addr[1] = 12'h0AB;

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_status", 32'(status), 32'(MATRIX_OP_STATUS_IDLE));
      check("rst_unit_start", 32'(unit_start), 0);
      check("rst_read_addr", 32'(read_addr), 0);
      check("rst_fanback", 32'(unit_writer_ready), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Normal op on unit 1, with a second command ignored while it runs
      s0 = start_cnt; d0 = done_cnt;
      issue(3'd1, 3'd2, 3'd3);
      check("t1_busy_check", 32'(busy), 1);
      check("t1_no_start_yet", 32'(unit_start), 0);
      @(negedge clk);
      check("t1_unit_start", 32'(unit_start), 32'b0010);
      check("t1_a_id", 32'(unit_a_id), 2);
      check("t1_b_id", 32'(unit_b_id), 3);
      check("t1_status_busy", 32'(status), 32'(MATRIX_OP_STATUS_BUSY));
      check("t1_read_addr", 32'(read_addr), 32'h0AB);
      unit_busy[1] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 10) begin cmd_start = 1'b1; cmd_op = 3'd3; cmd_a_id = 3'd7; cmd_b_id = 3'd6; end
         if (i == 11) cmd_start = 1'b0;
      end
      check("t1_run_start_pulse", 32'(unit_start), 0);
      unit_busy[1] = 1'b0;
      unit_status[1] = MATRIX_OP_STATUS_SUCCESS;
      wait_done(8, n);
      check("t1_done_latency", 32'(n), 2);
      check("t1_status", 32'(status), 32'(MATRIX_OP_STATUS_SUCCESS));
      check("t1_a_id_held", 32'(unit_a_id), 2);
      @(negedge clk);
      check("t1_done_one_cycle", 32'(done), 0);
      check("t1_idle_busy", 32'(busy), 0);
      check("t1_status_held", 32'(status), 32'(MATRIX_OP_STATUS_SUCCESS));
      repeat (4) @(negedge clk);
      check("t1_one_start", 32'(start_cnt - s0), 1);
      check("t1_one_done", 32'(done_cnt - d0), 1);

      // Out-of-range op code
      s0 = start_cnt;
      issue(3'd5, 3'd1, 3'd1);
      wait_done(8, n);
      check("t2_status", 32'(status), 32'(MATRIX_OP_STATUS_ERR_ID));
      check("t2_no_start", 32'(start_cnt - s0), 0);
      @(negedge clk);

      // Unit never raises busy
      issue(3'd0, 3'd0, 3'd1);
      @(negedge clk);
      check("t3_unit_start", 32'(unit_start), 32'b0001);
      wait_done(40, n);
      check("t3_timeout_cycles", 32'(n), 17);
      check("t3_status", 32'(status), 32'(MATRIX_OP_STATUS_ERR_INTERNAL));
      @(negedge clk);

      // Port mux and fan-back with unit 2 selected; one-cycle busy pulse
      unit_read_addr[0] = 12'h123; unit_read_addr[2] = 12'h045;
      unit_data_in[0] = 16'h1111;  unit_data_in[2] = 16'h2222;
      unit_matrix_id[2] = 3'd5;    unit_actual_rows[2] = 8'd7;
      unit_write_request = 4'b0101;
      writer_ready = 1'b1;
      issue(3'd2, 3'd4, 3'd5);
      check("t4_idle_fanback", 32'(unit_writer_ready), 0);
      @(negedge clk);
      check("t4_read_addr", 32'(read_addr), 32'h045);
      check("t4_fanback", 32'(unit_writer_ready), 32'b0100);
      check("t4_data_in", 32'(data_in), 32'h2222);
      check("t4_matrix_id", 32'(matrix_id), 5);
      check("t4_rows", 32'(actual_rows), 7);
      check("t4_write_req", 32'(write_request), 1);
      unit_busy[2] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t4_run_read_addr", 32'(read_addr), 32'h045);
      unit_busy[2] = 1'b0;
      unit_status[2] = MATRIX_OP_STATUS_ERR_DIM;
      wait_done(8, n);
      check("t4_done_latency", 32'(n), 2);
      check("t4_status", 32'(status), 32'(MATRIX_OP_STATUS_ERR_DIM));
      check("t4_done_mux_off", 32'(read_addr), 0);
      check("t4_done_fanback_off", 32'(unit_writer_ready), 0);
      writer_ready = 1'b0;
      @(negedge clk);

      // Asynchronous reset during RUN, then a clean command
      issue(3'd1, 3'd2, 3'd2);
      @(negedge clk);
      unit_busy[1] = 1'b1;
      repeat (3) @(negedge clk);
      check("t5_running", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_busy", 32'(busy), 0);
      check("t5_rst_status", 32'(status), 32'(MATRIX_OP_STATUS_IDLE));
      check("t5_rst_read_addr", 32'(read_addr), 0);
      unit_busy[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(3'd3, 3'd1, 3'd4);
      @(negedge clk);
      check("t5_unit_start", 32'(unit_start), 32'b1000);
      check("t5_a_id", 32'(unit_a_id), 1);
      unit_busy[3] = 1'b1;
      repeat (3) @(negedge clk);
      unit_busy[3] = 1'b0;
      unit_status[3] = MATRIX_OP_STATUS_SUCCESS;
      wait_done(8, n);
      check("t5_done_latency", 32'(n), 2);
      check("t5_status", 32'(status), 32'(MATRIX_OP_STATUS_SUCCESS));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
